// File: rtl/fetch_unit.sv
// Two-byte instruction fetcher sharing a single synchronous memory port with executor data accesses.
// Fetch runs HI/LO/CAP into WAIT; data reads and writes are serviced only from WAIT.
module fetch_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   pc_addr_i,
  output logic [1:0]          pc_op_o,
  output logic [7:0]          pc_k_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_rw_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_q_i,
  output logic [2*DATA_W-1:0] instr_o,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  input  logic                jump_taken_i,
  input  logic                data_req_i,
  input  logic                data_rw_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_ack_o
);

  localparam logic [1:0] PcReset = 2'b00;
  localparam logic [1:0] PcHold  = 2'b01;
  localparam logic [1:0] PcIncr  = 2'b10;
  localparam logic [1:0] PcJump  = 2'b11;

  typedef enum logic [2:0] {
    StBoot,
    StHi,
    StLo,
    StCap,
    StWait,
    StDrd,
    StDcap,
    StDwr
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   instr_hi_q, instr_hi_d;
  logic [DATA_W-1:0]   instr_lo_q, instr_lo_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                data_ack_q, data_ack_d;
  logic                pend_q, pend_d;
  logic                req_eff;

  // The ack cycle ignores new requests so one access cannot be retriggered by a held req.
  assign req_eff = (data_req_i | pend_q) & ~data_ack_q;

  always_comb begin
    state_d      = state_q;
    instr_hi_d   = instr_hi_q;
    instr_lo_d   = instr_lo_q;
    data_rdata_d = data_rdata_q;
    data_ack_d   = 1'b0;
    pend_d       = pend_q;
    pc_op_o      = PcHold;
    mem_addr_o   = pc_addr_i;
    mem_rw_o     = 1'b0;

    unique case (state_q)
      StBoot: begin
        pc_op_o = PcReset;
        state_d = StHi;
      end
      StHi: begin
        if (data_req_i) pend_d = 1'b1;
        state_d = StLo;
      end
      StLo: begin
        if (data_req_i) pend_d = 1'b1;
        mem_addr_o = pc_addr_i + ADDR_W'(1);
        instr_hi_d = mem_q_i;
        state_d    = StCap;
      end
      StCap: begin
        if (data_req_i) pend_d = 1'b1;
        instr_lo_d = mem_q_i;
        state_d    = StWait;
      end
      StWait: begin
        if (req_eff) begin
          pend_d  = 1'b0;
          state_d = data_rw_i ? StDwr : StDrd;
        end else if (instr_ready_i) begin
          pc_op_o = jump_taken_i ? PcJump : PcIncr;
          state_d = StHi;
        end
      end
      StDwr: begin
        mem_addr_o = data_addr_i;
        mem_rw_o   = 1'b1;
        data_ack_d = 1'b1;
        state_d    = StWait;
      end
      StDrd: begin
        mem_addr_o = data_addr_i;
        state_d    = StDcap;
      end
      StDcap: begin
        data_rdata_d = mem_q_i;
        data_ack_d   = 1'b1;
        state_d      = StWait;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      instr_hi_q   <= '0;
      instr_lo_q   <= '0;
      data_rdata_q <= '0;
      data_ack_q   <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_hi_q   <= instr_hi_d;
      instr_lo_q   <= instr_lo_d;
      data_rdata_q <= data_rdata_d;
      data_ack_q   <= data_ack_d;
      pend_q       <= pend_d;
    end
  end

  assign instr_o       = {instr_hi_q, instr_lo_q};
  assign instr_valid_o = (state_q == StWait);
  assign pc_k_o        = instr_lo_q[7:0];
  assign mem_wdata_o   = data_wdata_i;
  assign data_rdata_o  = data_rdata_q;
  assign data_ack_o    = data_ack_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: byte memory and program counter modelled locally,
// outputs sampled 1 time unit after the rising edge.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        pc_op;
  logic [7:0]        pc_k;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic              jump_taken = 1'b0;
  logic              data_req = 1'b0;
  logic              data_rw = 1'b0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [DATA_W-1:0] data_wdata = '0;
  logic [DATA_W-1:0] data_rdata;
  logic              data_ack;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_addr_i    (pc_q),
    .pc_op_o      (pc_op),
    .pc_k_o       (pc_k),
    .mem_addr_o   (mem_addr),
    .mem_rw_o     (mem_rw),
    .mem_wdata_o  (mem_wdata),
    .mem_q_i      (mem_q),
    .instr_o      (instr),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .jump_taken_i (jump_taken),
    .data_req_i   (data_req),
    .data_rw_i    (data_rw),
    .data_addr_i  (data_addr),
    .data_wdata_i (data_wdata),
    .data_rdata_o (data_rdata),
    .data_ack_o   (data_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr] <= mem_wdata;
    mem_q <= mem[mem_addr];
  end

  // Jump offset counts in 2-byte instruction words.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else begin
      case (pc_op)
        2'b00:   pc_q <= '0;
        2'b10:   pc_q <= pc_q + 16'd2;
        2'b11:   pc_q <= pc_q + {{7{pc_k[7]}}, pc_k, 1'b0};
        default: pc_q <= pc_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34;
    mem[16'h0002] = 8'h20; mem[16'h0003] = 8'h07;
    mem[16'h000C] = 8'hAB; mem[16'h000D] = 8'hCD;
    mem[16'h000E] = 8'h11; mem[16'h000F] = 8'h22;
    mem[16'h0010] = 8'h20; mem[16'h0011] = 8'hFE;
    mem[16'h0040] = 8'h00; mem[16'h0050] = 8'h00;

    step(); step();
    check("rst_pc_op", 32'(pc_op), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_ack", 32'(data_ack), 32'h0);
    check("rst_rw", 32'(mem_rw), 32'h0);
    check("rst_rdata", 32'(data_rdata), 32'h0);

    rst_n = 1'b1;
    #1 check("boot_pc_op", 32'(pc_op), 32'h0);
    step();
    check("hi_addr", 32'(mem_addr), 32'h0000);
    check("hi_pc_op", 32'(pc_op), 32'h1);
    step();
    check("lo_addr", 32'(mem_addr), 32'h0001);
    step();
    check("cap_valid", 32'(instr_valid), 32'h0);
    step();
    check("first_valid", 32'(instr_valid), 32'h1);
    check("first_instr", 32'(instr), 32'h1234);
    step();
    check("hold_pc_op", 32'(pc_op), 32'h1);
    check("hold_valid", 32'(instr_valid), 32'h1);

    // Sequential accept at pc 0.
    instr_ready = 1'b1; jump_taken = 1'b0;
    #1 check("incr_pc_op", 32'(pc_op), 32'h2);
    step(); instr_ready = 1'b0;
    check("incr_hi_addr", 32'(mem_addr), 32'h0002);
    check("incr_hi_pc_op", 32'(pc_op), 32'h1);
    step(); step(); step();
    check("instr_2", 32'(instr), 32'h2007);

    instr_ready = 1'b1; jump_taken = 1'b1;
    #1 check("jump1_pc_op", 32'(pc_op), 32'h3);
    step(); instr_ready = 1'b0; jump_taken = 1'b0;
    check("jump1_addr", 32'(mem_addr), 32'h0010);
    step(); step(); step();
    check("instr_10", 32'(instr), 32'h20FE);
    check("pc_k_fe", 32'(pc_k), 32'hFE);

    instr_ready = 1'b1; jump_taken = 1'b1;
    #1 check("jump2_pc_op", 32'(pc_op), 32'h3);
    step(); instr_ready = 1'b0; jump_taken = 1'b0;
    check("jump2_addr", 32'(mem_addr), 32'h000C);
    step(); step(); step();
    check("instr_0c", 32'(instr), 32'hABCD);

    // Data write then read of 0x0040.
    data_req = 1'b1; data_rw = 1'b1; data_addr = 16'h0040; data_wdata = 8'hA5;
    #1 check("wr_req_pc_op", 32'(pc_op), 32'h1);
    step(); data_req = 1'b0;
    check("dwr_rw", 32'(mem_rw), 32'h1);
    check("dwr_addr", 32'(mem_addr), 32'h0040);
    check("dwr_ack", 32'(data_ack), 32'h0);
    step();
    check("wr_ack", 32'(data_ack), 32'h1);
    check("wr_ack_rw", 32'(mem_rw), 32'h0);
    check("wr_ack_valid", 32'(instr_valid), 32'h1);
    step();
    check("wr_ack_drop", 32'(data_ack), 32'h0);

    data_req = 1'b1; data_rw = 1'b0;
    step(); data_req = 1'b0;
    check("drd_addr", 32'(mem_addr), 32'h0040);
    check("drd_rw", 32'(mem_rw), 32'h0);
    step();
    check("dcap_ack", 32'(data_ack), 32'h0);
    step();
    check("rd_ack", 32'(data_ack), 32'h1);
    check("rd_data", 32'(data_rdata), 32'hA5);

    // Data request and instr_ready together: access goes first.
    step();
    data_req = 1'b1; data_rw = 1'b0; data_addr = 16'h000C; instr_ready = 1'b1;
    #1 check("prio_pc_op", 32'(pc_op), 32'h1);
    step(); data_req = 1'b0;
    check("prio_drd_addr", 32'(mem_addr), 32'h000C);
    check("prio_drd_pc_op", 32'(pc_op), 32'h1);
    step(); step();
    check("prio_ack", 32'(data_ack), 32'h1);
    check("prio_rdata", 32'(data_rdata), 32'hAB);
    check("prio_valid", 32'(instr_valid), 32'h1);
    check("prio_instr", 32'(instr), 32'hABCD);
    check("prio_accept", 32'(pc_op), 32'h2);
    step(); instr_ready = 1'b0;
    check("prio_hi_addr", 32'(mem_addr), 32'h000E);

    // Request pulsed during HI is held until WAIT.
    data_req = 1'b1; data_rw = 1'b1; data_addr = 16'h0050; data_wdata = 8'h3C;
    step(); data_req = 1'b0;
    step(); step();
    check("pend_instr", 32'(instr), 32'h1122);
    check("pend_pc_op", 32'(pc_op), 32'h1);
    step();
    check("pend_dwr_rw", 32'(mem_rw), 32'h1);
    check("pend_dwr_addr", 32'(mem_addr), 32'h0050);
    step();
    check("pend_ack", 32'(data_ack), 32'h1);
    check("pend_mem", 32'(mem[16'h0050]), 32'h3C);

    // Reset during LO with a pending write discards both.
    instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    check("pre_rst_hi_addr", 32'(mem_addr), 32'h0010);
    data_req = 1'b1; data_rw = 1'b1;
    step(); data_req = 1'b0;
    check("pre_rst_lo_addr", 32'(mem_addr), 32'h0011);
    rst_n = 1'b0;
    #1;
    check("lo_rst_pc_op", 32'(pc_op), 32'h0);
    check("lo_rst_instr", 32'(instr), 32'h0);
    check("lo_rst_valid", 32'(instr_valid), 32'h0);
    check("lo_rst_rw", 32'(mem_rw), 32'h0);
    check("lo_rst_ack", 32'(data_ack), 32'h0);
    check("lo_rst_rdata", 32'(data_rdata), 32'h0);
    step();
    rst_n = 1'b1;
    #1 check("reboot_pc_op", 32'(pc_op), 32'h0);
    step();
    check("refetch_addr", 32'(mem_addr), 32'h0000);
    step(); step(); step();
    check("refetch_instr", 32'(instr), 32'h1234);
    step();
    check("no_stale_rw", 32'(mem_rw), 32'h0);
    check("no_stale_valid", 32'(instr_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1);
  end

endmodule
